// File: rtl/axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_master
// Brief    : Turns command/stream requests into single-ID AXI4 INCR bursts,
//            with one independent write and one read transaction in flight.
// Revision : 1.0  initial release
// ============================================================================
module axi_burst_master #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 16,
  parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                  ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  // write command / payload / status
  input  logic [ADDR_WIDTH-1:0] s_wr_cmd_addr,
  input  logic [7:0]            s_wr_cmd_len,
  input  logic                  s_wr_cmd_valid,
  output logic                  s_wr_cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_wr_data,
  input  logic                  s_wr_data_valid,
  output logic                  s_wr_data_ready,
  output logic [1:0]            m_wr_status_resp,
  output logic                  m_wr_status_valid,
  // read command / payload
  input  logic [ADDR_WIDTH-1:0] s_rd_cmd_addr,
  input  logic [7:0]            s_rd_cmd_len,
  input  logic                  s_rd_cmd_valid,
  output logic                  s_rd_cmd_ready,
  output logic [DATA_WIDTH-1:0] m_rd_data,
  output logic [1:0]            m_rd_resp,
  output logic                  m_rd_last,
  output logic                  m_rd_valid,
  input  logic                  m_rd_ready,
  output logic                  m_rd_err,
  output logic                  wr_busy,
  output logic                  rd_busy,
  // AXI4 write address
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI4 write data
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI4 write response
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI4 read address
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI4 read data
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int                    c_ADDR_LSB  = $clog2(STRB_WIDTH);
  localparam logic [2:0]            c_SIZE      = 3'(c_ADDR_LSB);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ADDR = 2'd1, WR_DATA = 2'd2, WR_RESP = 2'd3} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_state_t;

  wr_state_t             r_wr_state, w_wr_next;
  rd_state_t             r_rd_state, w_rd_next;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [7:0]            r_awlen, r_arlen, r_wr_cnt, r_rd_cnt;
  logic                  r_wr_status_valid, r_rd_err;
  logic [1:0]            r_wr_status_resp;
  logic                  w_wr_cmd_hs, w_w_hs, w_b_hs, w_rd_cmd_hs, w_r_hs;
  logic                  w_unused_ids;

  assign w_unused_ids = ^{m_axi_bid, m_axi_rid};

  // ---------------------------------------------------------------- write
  always_ff @(posedge clk) begin
    if (rst) r_wr_state <= WR_IDLE;
    else     r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next       = r_wr_state;
    w_wr_cmd_hs     = 1'b0;
    w_w_hs          = 1'b0;
    w_b_hs          = 1'b0;
    s_wr_cmd_ready  = 1'b0;
    m_axi_awvalid   = 1'b0;
    m_axi_wvalid    = 1'b0;
    s_wr_data_ready = 1'b0;
    m_axi_bready    = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        s_wr_cmd_ready = !rst;
        if (s_wr_cmd_valid && !rst) begin
          w_wr_cmd_hs = 1'b1;
          w_wr_next   = WR_ADDR;
        end
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) w_wr_next = WR_DATA;
      end
      WR_DATA: begin
        m_axi_wvalid    = s_wr_data_valid;
        s_wr_data_ready = m_axi_wready;
        if (s_wr_data_valid && m_axi_wready) begin
          w_w_hs = 1'b1;
          if (r_wr_cnt == 8'd0) w_wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          w_b_hs    = 1'b1;
          w_wr_next = WR_IDLE;
        end
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awaddr          <= '0;
      r_awlen           <= '0;
      r_wr_cnt          <= '0;
      r_wr_status_valid <= 1'b0;
      r_wr_status_resp  <= 2'b00;
    end else begin
      r_wr_status_valid <= w_b_hs;
      if (w_b_hs) r_wr_status_resp <= m_axi_bresp;
      if (w_wr_cmd_hs) begin
        r_awaddr <= s_wr_cmd_addr & c_ADDR_MASK;
        r_awlen  <= s_wr_cmd_len;
        r_wr_cnt <= s_wr_cmd_len;
      end else if (w_w_hs) begin
        r_wr_cnt <= r_wr_cnt - 8'd1;
      end
    end
  end

  // ----------------------------------------------------------------- read
  always_ff @(posedge clk) begin
    if (rst) r_rd_state <= RD_IDLE;
    else     r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next      = r_rd_state;
    w_rd_cmd_hs    = 1'b0;
    w_r_hs         = 1'b0;
    s_rd_cmd_ready = 1'b0;
    m_axi_arvalid  = 1'b0;
    m_rd_valid     = 1'b0;
    m_axi_rready   = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        s_rd_cmd_ready = !rst;
        if (s_rd_cmd_valid && !rst) begin
          w_rd_cmd_hs = 1'b1;
          w_rd_next   = RD_ADDR;
        end
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) w_rd_next = RD_DATA;
      end
      RD_DATA: begin
        m_rd_valid   = m_axi_rvalid;
        m_axi_rready = m_rd_ready;
        if (m_axi_rvalid && m_rd_ready) begin
          w_r_hs = 1'b1;
          // Leave on whichever of rlast / exhausted count arrives first
          if (m_axi_rlast || r_rd_cnt == 8'd0) w_rd_next = RD_IDLE;
        end
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_araddr <= '0;
      r_arlen  <= '0;
      r_rd_cnt <= '0;
      r_rd_err <= 1'b0;
    end else begin
      r_rd_err <= w_r_hs && (m_axi_rlast != (r_rd_cnt == 8'd0));
      if (w_rd_cmd_hs) begin
        r_araddr <= s_rd_cmd_addr & c_ADDR_MASK;
        r_arlen  <= s_rd_cmd_len;
        r_rd_cnt <= s_rd_cmd_len;
      end else if (w_r_hs) begin
        r_rd_cnt <= r_rd_cnt - 8'd1;
      end
    end
  end

  // ------------------------------------------------------------- outputs
  assign m_wr_status_valid = r_wr_status_valid;
  assign m_wr_status_resp  = r_wr_status_resp;
  assign m_rd_err          = r_rd_err;
  assign wr_busy           = (r_wr_state != WR_IDLE);
  assign rd_busy           = (r_rd_state != RD_IDLE);

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = c_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b010;
  assign m_axi_wdata   = s_wr_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (r_wr_state == WR_DATA) && (r_wr_cnt == 8'd0);

  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = c_SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b010;
  assign m_rd_data     = m_axi_rdata;
  assign m_rd_resp     = m_axi_rresp;
  assign m_rd_last     = m_axi_rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_burst_master
// Brief    : Self-checking bench: AXI RAM responder, reference memory model,
//            table vectors, hand sequences and randomized bursts.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_burst_master;

  localparam int MEM_WORDS = 16384;
  localparam int BOUND     = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_wr_cmd_addr, s_rd_cmd_addr;
  logic [7:0]  s_wr_cmd_len, s_rd_cmd_len;
  logic        s_wr_cmd_valid, s_wr_cmd_ready, s_rd_cmd_valid, s_rd_cmd_ready;
  logic [31:0] s_wr_data, m_rd_data;
  logic        s_wr_data_valid, s_wr_data_ready;
  logic [1:0]  m_wr_status_resp, m_rd_resp;
  logic        m_wr_status_valid, m_rd_last, m_rd_valid, m_rd_ready, m_rd_err;
  logic        wr_busy, rd_busy;
  logic [7:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .s_wr_cmd_addr(s_wr_cmd_addr), .s_wr_cmd_len(s_wr_cmd_len),
    .s_wr_cmd_valid(s_wr_cmd_valid), .s_wr_cmd_ready(s_wr_cmd_ready),
    .s_wr_data(s_wr_data), .s_wr_data_valid(s_wr_data_valid), .s_wr_data_ready(s_wr_data_ready),
    .m_wr_status_resp(m_wr_status_resp), .m_wr_status_valid(m_wr_status_valid),
    .s_rd_cmd_addr(s_rd_cmd_addr), .s_rd_cmd_len(s_rd_cmd_len),
    .s_rd_cmd_valid(s_rd_cmd_valid), .s_rd_cmd_ready(s_rd_cmd_ready),
    .m_rd_data(m_rd_data), .m_rd_resp(m_rd_resp), .m_rd_last(m_rd_last),
    .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_err(m_rd_err),
    .wr_busy(wr_busy), .rd_busy(rd_busy),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0, failures = 0, cyc = 0, err_cnt = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (m_rd_err === 1'b1) err_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return int'(a[15:2]);
  endfunction

  // Reference memory: what the bench intends the RAM to hold
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] ram     [MEM_WORDS];

  // Responder configuration and state
  int         cfg_aw_delay = 0, cfg_ar_delay = 0, cfg_rlast_at = -1;
  logic [1:0] cfg_bresp = 2'b00;
  bit         cfg_wready_rand = 0, cfg_rvalid_rand = 0;
  int         aw_wait = 0, aw_cyc = 0, aw_held = 0, w_beat = 0, ar_wait = 0;
  int         r_beat = 0, r_last_beat = 0;
  bit         aw_done = 0, b_pend = 0, r_act = 0, r_hold = 0;
  logic [15:0] cap_awaddr, cap_araddr;
  logic [7:0]  cap_awlen, cap_arlen;
  logic [2:0]  cap_awsize, cap_arsize, cap_awprot, cap_arprot;
  logic [1:0]  cap_awburst, cap_arburst;
  logic [3:0]  cap_awcache, cap_arcache;
  logic        cap_awlock, cap_arlock;
  logic [7:0]  cap_awid, cap_arid;

  // AXI RAM responder: drive on the falling edge, then book the handshakes
  // that the next rising edge will complete.
  always @(negedge clk) begin
    m_axi_bid = 8'h0; m_axi_rid = 8'h0; m_axi_rresp = 2'b00;
    if (rst) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = 0;
    end else begin
      m_axi_awready = m_axi_awvalid && (aw_wait >= cfg_aw_delay);
      m_axi_wready  = cfg_wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_bvalid  = b_pend;
      m_axi_bresp   = cfg_bresp;
      m_axi_arready = m_axi_arvalid && (ar_wait >= cfg_ar_delay);
      m_axi_rvalid  = r_act && (r_hold || !cfg_rvalid_rand || 1'($urandom_range(0, 1)));
      m_axi_rdata   = ram[(widx(cap_araddr) + r_beat) & (MEM_WORDS - 1)];
      m_axi_rlast   = r_act && (r_beat == r_last_beat);
    end
    #1;
    if (rst) begin
      aw_wait = 0; aw_cyc = 0; aw_done = 0; b_pend = 0; w_beat = 0;
      ar_wait = 0; r_act = 0; r_hold = 0; r_beat = 0;
    end else begin
      if (m_axi_awvalid) begin
        aw_cyc++;
        if (m_axi_awready) begin
          cap_awaddr = m_axi_awaddr; cap_awlen = m_axi_awlen; cap_awsize = m_axi_awsize;
          cap_awburst = m_axi_awburst; cap_awlock = m_axi_awlock; cap_awcache = m_axi_awcache;
          cap_awprot = m_axi_awprot; cap_awid = m_axi_awid;
          aw_held = aw_cyc; aw_cyc = 0; aw_wait = 0; aw_done = 1; w_beat = 0;
        end else aw_wait++;
      end
      if (m_axi_wvalid) chk("w_after_aw", aw_done, 1);
      if (m_axi_wvalid && m_axi_wready) begin
        chk("wstrb", m_axi_wstrb, 4'hF);
        chk("wlast", m_axi_wlast, w_beat == int'(cap_awlen));
        ram[(widx(cap_awaddr) + w_beat) & (MEM_WORDS - 1)] = m_axi_wdata;
        w_beat++;
        if (m_axi_wlast) begin aw_done = 0; b_pend = 1; end
      end
      if (m_axi_bvalid && m_axi_bready) b_pend = 0;
      if (m_axi_arvalid) begin
        if (m_axi_arready) begin
          cap_araddr = m_axi_araddr; cap_arlen = m_axi_arlen; cap_arsize = m_axi_arsize;
          cap_arburst = m_axi_arburst; cap_arlock = m_axi_arlock; cap_arcache = m_axi_arcache;
          cap_arprot = m_axi_arprot; cap_arid = m_axi_arid;
          ar_wait = 0; r_act = 1; r_beat = 0;
          r_last_beat = (cfg_rlast_at >= 0 && cfg_rlast_at < int'(m_axi_arlen)) ? cfg_rlast_at
                                                                                  : int'(m_axi_arlen);
        end else ar_wait++;
      end
      r_hold = m_axi_rvalid && !m_axi_rready;
      if (m_axi_rvalid && m_axi_rready) begin
        if (m_axi_rlast) r_act = 0;
        else r_beat++;
      end
    end
  end

  task automatic write_txn(input logic [15:0] addr, input logic [7:0] len, input int aw_delay,
                           input logic [1:0] bresp, input logic [1:0] exp_resp, input bit gaps,
                           output int hs_cyc);
    logic [31:0] data [$];
    logic [15:0] exp_addr;
    int n;
    bit done, acc;
    exp_addr = {addr[15:2], 2'b00};
    cfg_aw_delay = aw_delay;
    cfg_bresp = bresp;
    for (int i = 0; i <= int'(len); i++) data.push_back($urandom);
    hs_cyc = -1;
    @(negedge clk);
    s_wr_cmd_valid = 1; s_wr_cmd_addr = addr; s_wr_cmd_len = len;
    done = 0;
    for (int t = 0; t < BOUND && !done; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (s_wr_cmd_ready) begin done = 1; hs_cyc = cyc; end
    end
    @(negedge clk);
    s_wr_cmd_valid = 0;
    if (!done) begin chk("wr_cmd_timeout", 0, 1); return; end
    #1;
    chk("wr_cmd_ready_drop", s_wr_cmd_ready, 0);
    chk("awvalid_rise", m_axi_awvalid, 1);
    n = 0; acc = 0;
    for (int t = 0; t < BOUND && n <= int'(len); t++) begin
      @(negedge clk);
      if (!s_wr_data_valid || acc) begin
        s_wr_data_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        s_wr_data = data[n];
      end
      #1;
      acc = s_wr_data_valid && s_wr_data_ready;
      if (acc) n++;
    end
    @(negedge clk);
    s_wr_data_valid = 0;
    if (n <= int'(len)) begin chk("wr_data_timeout", n, len + 1); return; end
    done = 0;
    for (int t = 0; t < BOUND && !done; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (m_wr_status_valid) done = 1;
    end
    if (!done) begin chk("wr_status_timeout", 0, 1); return; end
    chk("wr_status_resp", m_wr_status_resp, exp_resp);
    chk("wr_idle_at_status", {s_wr_cmd_ready, wr_busy}, 2'b10);
    chk("awvalid_held", aw_held, aw_delay + 1);
    chk("awaddr", cap_awaddr, exp_addr);
    chk("awlen", cap_awlen, len);
    chk("aw_fixed", {cap_awid, cap_awsize, cap_awburst, cap_awlock, cap_awcache, cap_awprot},
        {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010});
    for (int i = 0; i <= int'(len); i++) begin
      ref_mem[(widx(addr) + i) & (MEM_WORDS - 1)] = data[i];
      chk("wr_ram_word", ram[(widx(addr) + i) & (MEM_WORDS - 1)], data[i]);
    end
    @(negedge clk); #1;
    chk("wr_status_pulse_width", m_wr_status_valid, 0);
  endtask

  task automatic read_txn(input logic [15:0] addr, input logic [7:0] len, input int ar_delay,
                          input int rlast_at, input int mode, output int hs_cyc);
    int exp_last, n, err0;
    bit done, got_last, tog;
    exp_last = (rlast_at >= 0 && rlast_at < int'(len)) ? rlast_at : int'(len);
    cfg_ar_delay = ar_delay;
    cfg_rlast_at = rlast_at;
    err0 = err_cnt;
    hs_cyc = -1;
    @(negedge clk);
    s_rd_cmd_valid = 1; s_rd_cmd_addr = addr; s_rd_cmd_len = len;
    done = 0;
    for (int t = 0; t < BOUND && !done; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (s_rd_cmd_ready) begin done = 1; hs_cyc = cyc; end
    end
    @(negedge clk);
    s_rd_cmd_valid = 0;
    if (!done) begin chk("rd_cmd_timeout", 0, 1); return; end
    #1;
    chk("rd_cmd_ready_drop", s_rd_cmd_ready, 0);
    chk("arvalid_rise", m_axi_arvalid, 1);
    n = 0; got_last = 0; tog = 1;
    for (int t = 0; t < BOUND && !got_last; t++) begin
      @(negedge clk);
      m_rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      #1;
      if (m_rd_valid) chk("rready_tracks", m_axi_rready, m_rd_ready);
      if (m_rd_valid && m_rd_ready) begin
        chk("rd_data", m_rd_data, ref_mem[(widx(addr) + n) & (MEM_WORDS - 1)]);
        chk("rd_resp", m_rd_resp, 2'b00);
        chk("rd_last", m_rd_last, n == exp_last);
        got_last = m_rd_last;
        n++;
      end
    end
    @(negedge clk);
    m_rd_ready = 0;
    #1;
    chk("rd_beats", n, exp_last + 1);
    chk("rd_idle_after", {s_rd_cmd_ready, rd_busy}, 2'b10);
    chk("araddr", cap_araddr, {addr[15:2], 2'b00});
    chk("arlen", cap_arlen, len);
    chk("ar_fixed", {cap_arid, cap_arsize, cap_arburst, cap_arlock, cap_arcache, cap_arprot},
        {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010});
    @(negedge clk); #1;
    chk("rd_err_pulses", err_cnt - err0, (exp_last != int'(len)) ? 1 : 0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    int          delay;
    logic [1:0]  bresp;
    int          rlast_at;
    int          rd_mode;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hw, hr, len, off, pg, rl;
    logic [1:0] br;
    vecs[0] = '{16'h0104, 8'd3, 2, 2'b00, -1, 1, 2'b00};
    vecs[1] = '{16'h0000, 8'd0, 0, 2'b00, -1, 0, 2'b00};
    vecs[2] = '{16'h0203, 8'd5, 1, 2'b10, -1, 2, 2'b10};
    vecs[3] = '{16'h0300, 8'd3, 0, 2'b00,  1, 0, 2'b00};
    vecs[4] = '{16'h0FF0, 8'd3, 3, 2'b11, -1, 1, 2'b11};
    for (int i = 0; i < MEM_WORDS; i++) begin ram[i] = 0; ref_mem[i] = 0; end
    s_wr_cmd_valid = 0; s_wr_cmd_addr = 0; s_wr_cmd_len = 0;
    s_wr_data_valid = 0; s_wr_data = 0;
    s_rd_cmd_valid = 0; s_rd_cmd_addr = 0; s_rd_cmd_len = 0; m_rd_ready = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", {s_wr_cmd_ready, s_rd_cmd_ready}, 2'b00);
    chk("rst_valids", {m_axi_awvalid, m_axi_arvalid, m_axi_bready, m_axi_wvalid}, 4'b0000);
    chk("rst_pulses_busy", {m_wr_status_valid, m_rd_err, wr_busy, rd_busy}, 4'b0000);
    chk("rst_aw_ar", {m_axi_awaddr, m_axi_awlen, m_axi_araddr, m_axi_arlen}, 48'h0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("idle_cmd_ready", {s_wr_cmd_ready, s_rd_cmd_ready}, 2'b11);

    for (int i = 0; i < 5; i++) begin
      write_txn(vecs[i].addr, vecs[i].len, vecs[i].delay, vecs[i].bresp, vecs[i].exp_resp, 0, hw);
      read_txn(vecs[i].addr, vecs[i].len, vecs[i].delay, vecs[i].rlast_at, vecs[i].rd_mode, hr);
    end

    // Simultaneous commands in both directions
    fork
      write_txn(16'h2000, 8'd2, 1, 2'b00, 2'b00, 0, hw);
      read_txn(16'h0104, 8'd3, 0, -1, 0, hr);
    join
    chk("simul_cmd_same_cycle", hw, hr);

    // Reset during W beat 2 of an 8-beat burst
    cfg_aw_delay = 0;
    @(negedge clk);
    s_wr_cmd_valid = 1; s_wr_cmd_addr = 16'h3000; s_wr_cmd_len = 8'd7;
    #1 chk("rstseq_cmd_ready", s_wr_cmd_ready, 1);
    @(negedge clk); s_wr_cmd_valid = 0;
    @(negedge clk); s_wr_data_valid = 1; s_wr_data = 32'h1111_1111;
    @(negedge clk); s_wr_data = 32'h2222_2222; rst = 1;
    #1 chk("rstseq_beat2_wvalid", m_axi_wvalid, 1);
    @(negedge clk); #1;
    chk("rstseq_valids_drop", {m_axi_wvalid, m_axi_awvalid, m_axi_bready}, 3'b000);
    chk("rstseq_busy", {wr_busy, rd_busy}, 2'b00);
    @(negedge clk);
    rst = 0; s_wr_data_valid = 0;
    write_txn(16'h3000, 8'd7, 0, 2'b00, 2'b00, 0, hw);
    read_txn(16'h3000, 8'd7, 0, -1, 0, hr);

    // Randomized bursts against the reference memory
    cfg_wready_rand = 1;
    cfg_rvalid_rand = 1;
    for (int it = 0; it < 16; it++) begin
      len = $urandom_range(0, 15);
      pg  = $urandom_range(4, 15);
      off = $urandom_range(0, 1024 - (len + 1)) * 4 + $urandom_range(0, 3);
      br  = 2'($urandom_range(0, 3));
      rl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
      write_txn(16'(pg * 4096 + off), 8'(len), $urandom_range(0, 3), br, br, 1, hw);
      read_txn(16'(pg * 4096 + off), 8'(len), $urandom_range(0, 3), rl, $urandom_range(0, 2), hr);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
